// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter.
// Latency: n/a (types, constants and register layout only).
// Backpressure: n/a.
package uart_pkg;

    // Transmit FSM encodings
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    // Register offsets on uartaddr[1:0]
    localparam logic [1:0] UART_DATA = 2'b00;
    localparam logic [1:0] UART_STAT = 2'b10;

    // Status register bit positions
    localparam int ST_BUSY   = 0;
    localparam int ST_FULL   = 1;
    localparam int ST_EMPTY  = 2;
    localparam int ST_OVF    = 3;
    localparam int ST_CNT_LO = 4;
    localparam int ST_CNT_W  = 4;

endpackage

// File: rtl/uart_tx_io_if.sv
// CPU IO-bus view of the UART: chip select, strobes, address, write and read data.
// Latency: n/a (wires only).
// Backpressure: none; the bus never stalls, overflowing writes are dropped by the slave.
interface uart_tx_io_if;
    logic        uartcs;
    logic        uartwrite;
    logic        uartread;
    logic [1:0]  uartaddr;
    logic [15:0] uartwdata;
    logic [15:0] uartrdata;

    modport master (
        output uartcs, uartwrite, uartread, uartaddr, uartwdata,
        input  uartrdata
    );

    modport slave (
        input  uartcs, uartwrite, uartread, uartaddr, uartwdata,
        output uartrdata
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// DEPTH x 8 synchronous FIFO with an explicit occupancy count.
// Latency: pushed byte visible on pop_dat the cycle after the push edge.
// Backpressure: push refused when full unless a pop happens on the same edge.
module uart_tx_fifo #(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic [7:0] push_dat,
    input  logic       pop,
    output logic [7:0] pop_dat,
    output logic       push_ok,
    output logic       full,
    output logic       empty,
    output logic [3:0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          pop_ok;

    // A pop on the same edge frees a slot, so a full FIFO can still accept
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);
    assign full    = (count == 4'(DEPTH));
    assign empty   = (count == 4'd0);
    assign pop_dat = mem[rd_ptr];

    // Storage array, written only on an accepted push
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // Pointers wrap modulo DEPTH; count disambiguates full from empty
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= 4'd0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + {3'b000, push_ok} - {3'b000, pop_ok};
        end
    end
endmodule

// File: rtl/uart_tx_io.sv
// Memory-mapped 8N1 UART transmitter: CPU writes bytes into a FIFO, FSM serialises them.
// Latency: write on edge N into an idle, empty block drives the start bit at edge N+1.
// Backpressure: none on the bus; writes to a full FIFO are dropped and set sticky overflow.
module uart_tx_io
    import uart_pkg::*;
#(
    parameter int BAUD_DIV = 200,
    parameter int DEPTH    = 8
) (
    input  logic          uart_clk,
    input  logic          uartrst,
    uart_tx_io_if.slave   bus,
    output logic          tx_o,
    output logic          tx_busy_o
);
    tx_state_t   state;
    logic [15:0] bcnt;
    logic [2:0]  bidx;
    logic [7:0]  sh;

    logic        wr_hit;
    logic        rd_hit;
    logic        bit_end;
    logic        stop_end;
    logic        pop;
    logic        push_ok;
    logic        fifo_full;
    logic        fifo_empty;
    logic [3:0]  fifo_count;
    logic [3:0]  count_next;
    logic [7:0]  fifo_dat;
    logic        busy_next;
    logic        overflow;
    logic [15:0] status;
    logic [15:0] rdata;
    logic        unused_wdata;

    assign wr_hit   = bus.uartcs & bus.uartwrite & (bus.uartaddr == UART_DATA);
    assign rd_hit   = bus.uartcs & bus.uartread  & (bus.uartaddr == UART_STAT);
    assign bit_end  = (bcnt == 16'(BAUD_DIV - 1));
    assign stop_end = (state == STOP) & bit_end;

    // The FSM takes a byte when idle, or at the end of a stop bit for back-to-back frames
    assign pop = ~fifo_empty & ((state == IDLE) | stop_end);

    // Only the low byte of the write data is transmitted
    assign unused_wdata = ^bus.uartwdata[15:8];

    uart_tx_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk      (uart_clk),
        .rst      (uartrst),
        .push     (wr_hit),
        .push_dat (bus.uartwdata[7:0]),
        .pop      (pop),
        .pop_dat  (fifo_dat),
        .push_ok  (push_ok),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    // Busy is registered from next-cycle state so it lines up with tx_o
    assign count_next = fifo_count + {3'b000, push_ok} - {3'b000, pop};
    assign busy_next  = pop | ((state != IDLE) & ~stop_end) | (count_next != 4'd0);

    // Status word assembled from current register values
    always_comb begin
        status                              = '0;
        status[ST_BUSY]                     = tx_busy_o;
        status[ST_FULL]                     = fifo_full;
        status[ST_EMPTY]                    = fifo_empty;
        status[ST_OVF]                      = overflow;
        status[ST_CNT_LO +: ST_CNT_W]       = fifo_count;
    end

    assign bus.uartrdata = rdata;

    // Transmit FSM: start bit, 8 data bits LSB first, stop bit, each BAUD_DIV cycles
    always_ff @(posedge uart_clk) begin
        if (uartrst) begin
            state <= IDLE;
            bcnt  <= 16'd0;
            bidx  <= 3'd0;
            sh    <= 8'h00;
            tx_o  <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    tx_o <= 1'b1;
                    if (pop) begin
                        sh    <= fifo_dat;
                        tx_o  <= 1'b0;
                        bcnt  <= 16'd0;
                        state <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        tx_o  <= sh[0];
                        sh    <= {1'b0, sh[7:1]};
                        bidx  <= 3'd0;
                        bcnt  <= 16'd0;
                        state <= DATA;
                    end else begin
                        bcnt <= bcnt + 16'd1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        bcnt <= 16'd0;
                        if (bidx == 3'd7) begin
                            tx_o  <= 1'b1;
                            state <= STOP;
                        end else begin
                            tx_o <= sh[0];
                            sh   <= {1'b0, sh[7:1]};
                            bidx <= bidx + 3'd1;
                        end
                    end else begin
                        bcnt <= bcnt + 16'd1;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        bcnt <= 16'd0;
                        if (pop) begin
                            sh    <= fifo_dat;
                            tx_o  <= 1'b0;
                            state <= START;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        bcnt <= bcnt + 16'd1;
                    end
                end
                default: begin
                    tx_o  <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

    // Busy flag, status read register and sticky overflow (a new overflow beats the clear)
    always_ff @(posedge uart_clk) begin
        if (uartrst) begin
            tx_busy_o <= 1'b0;
            rdata     <= 16'h0000;
            overflow  <= 1'b0;
        end else begin
            tx_busy_o <= busy_next;
            if (rd_hit) begin
                rdata <= status;
            end
            if (wr_hit & ~push_ok) begin
                overflow <= 1'b1;
            end else if (rd_hit) begin
                overflow <= 1'b0;
            end
        end
    end
endmodule
